// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver. Scans one digit per DIGIT_TICKS
// cycles and shows a shadowed image that is only reloaded on frame boundaries.
module seg7_scan_driver #(
    parameter int unsigned DIGIT_TICKS = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  en_i,
    input  logic        lz_i,
    output logic [6:0]  HEX,
    output logic        DP,
    output logic [7:0]  AN
);

    localparam int unsigned CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   data_q;
    logic [7:0]    dp_q;
    logic [7:0]    en_q;
    logic          lz_q;
    logic          load_pending_q;

    logic          tick;
    logic          load;
    logic [2:0]    top;
    logic [3:0]    nib;
    logic          visible;
    logic [6:0]    hex_d;
    logic          dp_d;
    logic [7:0]    an_d;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 7'b1000000;
            4'h1: hex_font = 7'b1111001;
            4'h2: hex_font = 7'b0100100;
            4'h3: hex_font = 7'b0110000;
            4'h4: hex_font = 7'b0011001;
            4'h5: hex_font = 7'b0010010;
            4'h6: hex_font = 7'b0000010;
            4'h7: hex_font = 7'b1111000;
            4'h8: hex_font = 7'b0000000;
            4'h9: hex_font = 7'b0010000;
            4'hA: hex_font = 7'b0001000;
            4'hB: hex_font = 7'b0000011;
            4'hC: hex_font = 7'b1000110;
            4'hD: hex_font = 7'b0100001;
            4'hE: hex_font = 7'b0000110;
            default: hex_font = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tick  = (cnt_q == CW'(DIGIT_TICKS - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        load  = load_pending_q || (tick && (idx_q == 3'd7));

        // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 always shows.
        top = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (data_q[4*i +: 4] != 4'h0) top = 3'(i);
        end

        nib     = data_q[{idx_q, 2'b00} +: 4];
        visible = en_q[idx_q] && !(lz_q && (idx_q > top));

        hex_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!tick && visible) begin
            hex_d = hex_font(nib);
            dp_d  = ~dp_q[idx_q];
            an_d  = ~(8'd1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            data_q         <= '0;
            dp_q           <= '0;
            en_q           <= '0;
            lz_q           <= 1'b0;
            load_pending_q <= 1'b1;
            HEX            <= 7'h7F;
            DP             <= 1'b1;
            AN             <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (load) begin
                data_q         <= data_i;
                dp_q           <= dp_i;
                en_q           <= en_i;
                lz_q           <= lz_i;
                load_pending_q <= 1'b0;
            end
            HEX <= hex_d;
            DP  <= dp_d;
            AN  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver with DIGIT_TICKS = 4.
module tb_seg7_scan_driver;

    localparam int DT    = 4;
    localparam int FRAME = 8 * DT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_i = '0;
    logic [7:0]  dp_i = '0;
    logic [7:0]  en_i = '0;
    logic        lz_i = 1'b0;
    logic [6:0]  HEX;
    logic        DP;
    logic [7:0]  AN;

    int checks = 0;
    int failures = 0;

    seg7_scan_driver #(.DIGIT_TICKS(DT)) dut (
        .clk    (clk),
        .reset  (reset),
        .data_i (data_i),
        .dp_i   (dp_i),
        .en_i   (en_i),
        .lz_i   (lz_i),
        .HEX    (HEX),
        .DP     (DP),
        .AN     (AN)
    );

    always #5 clk = ~clk;

    // Font written as g..a, active low.
    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: p = cycles since reset released; image = latched inputs.
    int          p = 0;
    logic [31:0] s_data = '0;
    logic [7:0]  s_dp = '0;
    logic [7:0]  s_en = '0;
    logic        s_lz = 1'b0;
    logic [15:0] expq [$];

    function automatic logic [15:0] expected_image(input int slot, input int phase,
                                                   input logic [31:0] d, input logic [7:0] pt,
                                                   input logic [7:0] en, input logic lz);
        int   high;
        int   n;
        logic vis;
        high = 0;
        for (int i = 0; i < 8; i++)
            if (((d >> (4 * i)) & 32'hF) != 0) high = i;
        vis = en[slot] && !(lz && slot > high);
        n   = int'((d >> (4 * slot)) & 32'hF);
        if (phase == DT - 1 || !vis) return {7'h7F, 1'b1, 8'hFF};
        return {font[n], ~pt[slot], ~(8'(1) << slot)};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            expq.push_back({7'h7F, 1'b1, 8'hFF});
            p      = 0;
            s_data = '0;
            s_dp   = '0;
            s_en   = '0;
            s_lz   = 1'b0;
        end else begin
            expq.push_back(expected_image((p / DT) % 8, p % DT, s_data, s_dp, s_en, s_lz));
            if (p == 0 || (p % FRAME) == FRAME - 1) begin
                s_data = data_i;
                s_dp   = dp_i;
                s_en   = en_i;
                s_lz   = lz_i;
            end
            p = p + 1;
        end
    end

    always @(posedge clk) begin
        logic [15:0] e;
        #1;
        checks = checks + 1;
        if (expq.size() == 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_empty @%0t: got HEX=%b DP=%b AN=%h, required a queued expectation",
                     $time, HEX, DP, AN);
        end else begin
            e = expq.pop_front();
            if ({HEX, DP, AN} !== e) begin
                failures = failures + 1;
                $display("FAIL scan @%0t: got HEX=%b DP=%b AN=%h, required HEX=%b DP=%b AN=%h",
                         $time, HEX, DP, AN, e[15:9], e[8], e[7:0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_slot(input int slot);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((p / DT) % 8 == slot && p % DT == 1) return;
            @(negedge clk);
        end
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL wait_slot: got no slot %0d within %0d cycles, required it", slot, 2 * FRAME);
    endtask

    initial begin
        cyc(3);
        reset  = 1'b0;
        data_i = 32'h76543210;
        en_i   = 8'hFF;
        dp_i   = 8'h00;
        lz_i   = 1'b0;
        cyc(2 * FRAME);

        wait_slot(3);
        data_i = 32'hFFFFFFFF;
        cyc(FRAME + FRAME / 2);

        data_i = 32'h000000A0;
        lz_i   = 1'b1;
        en_i   = 8'hFF;
        cyc(2 * FRAME);

        lz_i = 1'b0;
        en_i = 8'h00;
        cyc(2 * FRAME);
        en_i = 8'hFF;
        dp_i = 8'h01;
        cyc(2 * FRAME);

        wait_slot(5);
        reset = 1'b1;
        cyc(2);
        reset  = 1'b0;
        data_i = 32'h0000BCDE;
        lz_i   = 1'b1;
        dp_i   = 8'h0A;
        cyc(1);
        data_i = 32'h12345678;
        cyc(FRAME + 4);

        for (int k = 0; k < 2000; k++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) begin
                data_i = $urandom >> $urandom_range(0, 31);
                dp_i   = 8'($urandom);
                en_i   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
                lz_i   = 1'($urandom);
            end
            cyc(1);
        end
        reset = 1'b0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter DIGIT_TICKS, default 100000, SHALL set the clock cycles per digit slot; legal values are 2 or greater.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 data_i  input  32  SHALL carry eight hex nibbles; digit i = data_i[4i+3:4i].
REQ-005 dp_i  input  8  SHALL carry decimal-point requests; bit i = 1 lights the point of digit i.
REQ-006 en_i  input  8  SHALL carry digit enables; bit i = 0 blanks digit i.
REQ-007 lz_i  input  1  SHALL enable leading-zero suppression when 1.
REQ-008 HEX  output  7  SHALL drive segments active-low, with HEX[0]=a through HEX[6]=g.
REQ-009 DP  output  1  SHALL drive the decimal point active-low.
REQ-010 AN  output  8  SHALL drive digit anodes active-low, with AN[i] selecting digit i.

Function
REQ-011 Prescaler cnt SHALL count 0..DIGIT_TICKS-1 and wrap to 0; tick = (cnt == DIGIT_TICKS-1).
REQ-012 Digit index idx (3 bit) SHALL advance by 1 on tick, wrapping 7 -> 0.
REQ-013 Shadow registers SHALL hold data_i, dp_i, en_i and lz_i; the displayed image uses the shadows only.
REQ-014 Shadows SHALL load on a frame boundary (tick with idx == 7) and on the first cycle after reset deasserts (load_pending flag, set by reset and cleared on that load).
REQ-015 An input change at any other time SHALL NOT alter the displayed digits until the next frame boundary (no tearing).
REQ-016 HEX, DP and AN SHALL be registered; each reflects the cnt, idx and shadow values of the previous cycle (1-cycle latency).
REQ-017 In the cycle after a tick cycle, AN SHALL be 8'hFF (a one-cycle ghosting guard); HEX and DP are don't-care, but SHALL be 7'h7F and 1.
REQ-018 Outside that guard cycle, AN SHALL equal ~(1 << idx) when digit idx is visible, else 8'hFF.
REQ-019 Digit idx SHALL be visible iff shadow en[idx] = 1 and the digit is not suppressed.
REQ-020 With shadow lz = 1, digits above the highest nonzero nibble SHALL be suppressed; digit 0 is never suppressed, so a value of 0 shows a single "0".
REQ-021 HEX SHALL use the standard hex font (0-9, A, b, C, d, E, F), e.g. 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
REQ-022 When the digit is not visible, HEX SHALL be 7'h7F.
REQ-023 DP SHALL be ~shadow dp[idx] when the digit is visible, else 1.
REQ-024 A full frame SHALL last exactly 8*DIGIT_TICKS cycles.
REQ-025 Each visible slot SHALL show AN low for DIGIT_TICKS-1 cycles, then one guard cycle.

Reset
REQ-026 While reset = 1, the block SHALL hold cnt = 0, idx = 0, all shadows = 0, load_pending = 1, HEX = 7'h7F, DP = 1 and AN = 8'hFF on the next edge.
REQ-027 Reset asserted mid-frame SHALL abort the frame.
REQ-028 After reset deasserts, scanning SHALL restart at digit 0 with freshly loaded shadows.
REQ-029 There SHALL be no reachable state from which the output returns to a non-reset pattern while reset = 1.

Verification (DIGIT_TICKS = 4)
REQ-030 Reset check: hold reset high for 3 cycles -> AN = FF, HEX = 7F and DP = 1 throughout.
REQ-031 Full scan: data_i = 32'h76543210, en_i = FF, lz_i = 0, dp_i = 0 -> AN cycles FE, FD, FB, F7, EF, DF, BF, 7F; each value lasts 3 cycles, separated by one FF cycle; HEX matches digit i.
REQ-032 Frame snapshot: change data_i to 32'hFFFFFFFF while idx = 3 -> digits 4..7 still show 4..7; F appears first at digit 0 of the next frame.
REQ-033 Leading-zero suppression: data_i = 32'h000000A0, lz_i = 1, en_i = FF -> only AN = FE (HEX 1000000) and AN = FD (HEX 0001000) are ever driven; all other slots read AN = FF.
REQ-034 Blanking and point: en_i = 8'h00 -> AN stays FF for a full frame; then en_i = FF, dp_i = 8'h01 -> DP = 0 only while AN = FE.
REQ-035 Reset mid-frame: assert reset while idx = 5 -> reset values appear on the next edge; after release, the first lit AN is FE with data_i as sampled on the first post-reset cycle.
